// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes NUM_DIGITS seven-segment patterns onto one shared segment bus with
//   one-hot digit enables. Each digit slot starts with BLANK_CYCLES of all-off time to
//   suppress ghosting. All patterns are snapshotted at the frame edge, so a digit never
//   changes mid-scan.
//
//   seg_in is taken as the pin-level pattern and passed through unchanged while a digit is
//   lit. Blank cycles drive the inactive level for the chosen polarity. dp_in is logical
//   (1 = lit) and is converted to pin polarity.
//
//   Optional macro SEVEN_SEG_SCANNER_DIM_EN adds a 3-bit 'bright' input. It shortens the lit
//   window to floor((bright+1)*L/8) cycles, where L = DIGIT_PERIOD-BLANK_CYCLES.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       scan enable; when low the counters and shadow hold and the outputs blank
//   seg_in       digit k pattern at [7k+6:7k], bit0 = segment a
//   dp_in        decimal point per digit, 1 = lit
//   bright       (DIM_EN only) brightness 0..7, 7 = full on
//   seg_out      shared segment bus
//   dp_out       shared decimal point
//   an_out       one-hot digit enables
//   frame_start  one-cycle pulse in the first cycle of each frame
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS       = 2,
    parameter int unsigned DIGIT_PERIOD     = 50000,
    parameter int unsigned BLANK_CYCLES     = 16,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    input  logic [2:0]              bright,
`endif
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);

    localparam int unsigned SW     = $clog2(DIGIT_PERIOD);
    localparam int unsigned IW     = $clog2(NUM_DIGITS);
    localparam int unsigned LitLen = DIGIT_PERIOD - BLANK_CYCLES;

    localparam logic [6:0]            SegOff   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DpOff    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AnOff    = DIGIT_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};
    localparam logic [SW-1:0]         SlotLast = SW'(DIGIT_PERIOD - 1);
    localparam logic [IW-1:0]         IdxLast  = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]           slot_q, slot_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7*NUM_DIGITS-1:0] shadow_seg_q, shadow_seg_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    logic [2:0]              shadow_bright_q, shadow_bright_d;
`endif

    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic                  frame_start_d;

    logic                  frame_edge;
    logic                  lit;
    int unsigned           slot_int;
    int unsigned           lit_len;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        slot_d          = slot_q;
        idx_d           = idx_q;
        shadow_seg_d    = shadow_seg_q;
        shadow_dp_d     = shadow_dp_q;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
        shadow_bright_d = shadow_bright_q;
`endif
        frame_edge      = enable && (slot_q == '0) && (idx_q == '0);
        slot_int        = 32'(slot_q);

`ifdef SEVEN_SEG_SCANNER_DIM_EN
        lit_len = ((32'(shadow_bright_q) + 32'd1) * LitLen) >> 3;
`else
        lit_len = LitLen;
`endif

        if (enable) begin
            if (slot_q == SlotLast) begin
                slot_d = '0;
                idx_d  = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end

        // Slot 0 is always blank, so loading the shadow on the same edge never shows a
        // half-updated pattern.
        if (frame_edge) begin
            shadow_seg_d    = seg_in;
            shadow_dp_d     = dp_in;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
            shadow_bright_d = bright;
`endif
        end

        lit = enable && (slot_int >= BLANK_CYCLES) && ((slot_int - BLANK_CYCLES) < lit_len);

        onehot         = '0;
        onehot[idx_q]  = 1'b1;

        seg_d         = SegOff;
        dp_d          = DpOff;
        an_d          = AnOff;
        frame_start_d = frame_edge;
        if (lit) begin
            seg_d = shadow_seg_q[7*int'(idx_q) +: 7];
            dp_d  = shadow_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
            an_d  = onehot ^ AnOff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q          <= '0;
            idx_q           <= '0;
            shadow_seg_q    <= {NUM_DIGITS{SegOff}};
            shadow_dp_q     <= '0;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
            shadow_bright_q <= 3'd7;
`endif
            seg_out         <= SegOff;
            dp_out          <= DpOff;
            an_out          <= AnOff;
            frame_start     <= 1'b0;
        end else begin
            slot_q          <= slot_d;
            idx_q           <= idx_d;
            shadow_seg_q    <= shadow_seg_d;
            shadow_dp_q     <= shadow_dp_d;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
            shadow_bright_q <= shadow_bright_d;
`endif
            seg_out         <= seg_d;
            dp_out          <= dp_d;
            an_out          <= an_d;
            frame_start     <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (2 digits, 8-cycle slots, 2 blank cycles,
// active-low segments and digits). A position-in-frame reference model predicts every
// output cycle by cycle. Directed steps cover reset, frame timing, snapshotting, enable
// gaps and asynchronous reset, followed by a randomized stretch.
module tb_seven_seg_scanner;

    localparam int N  = 2;
    localparam int DP = 8;
    localparam int BL = 2;
    localparam int FR = N * DP;

    logic          clk = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [13:0]   seg_in;
    logic [1:0]    dp_in;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [1:0]    an_out;
    logic          frame_start;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    logic [2:0]    bright;
`endif

    seven_seg_scanner #(
        .NUM_DIGITS      (N),
        .DIGIT_PERIOD    (DP),
        .BLANK_CYCLES    (BL),
        .SEG_ACTIVE_LOW  (1'b1),
        .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
`ifdef SEVEN_SEG_SCANNER_DIM_EN
        .bright     (bright),
`endif
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_start(frame_start)
    );

    always #5 if (clk_run) clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one integer position within the frame plus the snapshot.
    int         pos = 0;
    logic [13:0] snap_seg = 14'h3FFF;
    logic [1:0]  snap_dp  = 2'b00;
    int          snap_b   = 7;
    logic [1:0]  exp_an   = 2'b11;
    logic [6:0]  exp_seg  = 7'h7F;
    logic        exp_dp   = 1'b1;
    logic        exp_fs   = 1'b0;

    task automatic model_off();
        exp_an  = 2'b11;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_fs  = 1'b0;
    endtask

    task automatic model_reset();
        pos = 0;
        model_off();
    endtask

    task automatic model_edge();
        int d, s, on_len;
        logic [13:0] pat;
        if (!rst_n) begin
            model_reset();
        end else if (!enable) begin
            model_off();
        end else begin
            if (pos == 0) begin
                snap_seg = seg_in;
                snap_dp  = dp_in;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
                snap_b   = int'(bright);
`else
                snap_b   = 7;
`endif
            end
            d      = pos / DP;
            s      = pos % DP;
            on_len = ((snap_b + 1) * (DP - BL)) / 8;
            exp_fs = (pos == 0);
            if (s >= BL && (s - BL) < on_len) begin
                pat     = snap_seg >> (7 * d);
                exp_seg = pat[6:0];
                exp_dp  = ~snap_dp[d];
                exp_an  = (d == 0) ? 2'b10 : 2'b01;
            end else begin
                exp_an  = 2'b11;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end
            pos = (pos + 1) % FR;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, got, want, $time);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".an"},  32'(an_out),      32'(exp_an));
        chk({tag, ".seg"}, 32'(seg_out),     32'(exp_seg));
        chk({tag, ".dp"},  32'(dp_out),      32'(exp_dp));
        chk({tag, ".fs"},  32'(frame_start), 32'(exp_fs));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    int fs_gap;

    initial begin
        rst_n  = 1'b1;
        enable = 1'b0;
        seg_in = 14'h0;
        dp_in  = 2'b00;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
        bright = 3'd7;
`endif

        // Asynchronous reset with the clock stopped.
        #2 rst_n = 1'b0;
        #1;
        chk("rst.an",  32'(an_out),      32'h3);
        chk("rst.seg", 32'(seg_out),     32'h7F);
        chk("rst.dp",  32'(dp_out),      32'h1);
        chk("rst.fs",  32'(frame_start), 32'h0);
        model_reset();

        // Basic two-frame scan.
        seg_in  = {7'h79, 7'h40};
        dp_in   = 2'b10;
        enable  = 1'b1;
        clk_run = 1'b1;
        #1 rst_n = 1'b1;
        tick("f0");
        chk("f0.fs_first", 32'(frame_start), 32'h1);
        fs_gap = 0;
        for (int i = 0; i < 40 && !(fs_gap > 0 && frame_start); i++) begin
            tick("f0");
            fs_gap++;
        end
        chk("f0.fs_gap", 32'(fs_gap), 32'd16);
        ticks(FR - 1, "f1");

        // Pattern change mid-frame is deferred to the next frame.
        ticks(5, "snap");
        seg_in = {7'h24, 7'h30};
        ticks(FR - 5 + FR, "snap");

        // Enable gap during digit 0's lit window.
        ticks(5, "en");
        enable = 1'b0;
        ticks(5, "en_off");
        chk("en_off.an", 32'(an_out), 32'h3);
        enable = 1'b1;
        ticks(3, "en_resume");
        chk("en_resume.an", 32'(an_out), 32'h2);
        tick("en_blank");
        chk("en_blank.an", 32'(an_out), 32'h3);
        ticks(FR - 9 + FR, "en_tail");

`ifdef SEVEN_SEG_SCANNER_DIM_EN
        bright = 3'd3;
        ticks(2 * FR, "dim3");
        bright = 3'd7;
        ticks(FR, "dim7");
        ticks(4, "dim_mid");
        bright = 3'd1;
        ticks(FR - 4 + FR, "dim_mid");
`endif

        // Randomized stretch.
        for (int i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) seg_in = 14'($urandom);
            if ($urandom_range(0, 3) == 0) dp_in  = 2'($urandom);
`ifdef SEVEN_SEG_SCANNER_DIM_EN
            if ($urandom_range(0, 7) == 0) bright = 3'($urandom);
`endif
            tick("rand");
        end

        // Asynchronous reset in digit 1's lit window.
        enable = 1'b1;
        seg_in = {7'h79, 7'h40};
        dp_in  = 2'b10;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
        bright = 3'd7;
`endif
        ticks((11 - pos + FR) % FR + FR, "pre_rst");
        chk("pre_rst.an", 32'(an_out), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        tick("in_rst");
        rst_n = 1'b1;
        ticks(2 * FR, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish by t=100000");
        $fatal(1, "timeout");
    end

endmodule
